// File: rtl/sc_statemachine_pointtype_pkg.sv
// Shared types and defaults for the point-type rotate-register sequencer.
package sc_statemachine_pointtype_pkg;

    localparam int unsigned PRESCALER_WIDTH_DEF = 4;
    localparam logic [3:0]  PRESCALER_TERMINAL_DEF = 4'd9;
    localparam int unsigned STEP_WIDTH_DEF = 4;
    localparam logic [3:0]  STEP_COUNT_DEF = 4'd8;

    localparam int unsigned SHIFT_CODE_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } stateT;

    typedef enum logic [SHIFT_CODE_WIDTH-1:0] {
        SHIFT_HOLD  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10
    } shiftCodeT;

    // Rotation code for a latched direction: 0 rotates left, 1 rotates right.
    function automatic shiftCodeT shiftCodeFor(input logic dir);
        return dir ? SHIFT_RIGHT : SHIFT_LEFT;
    endfunction

endpackage

// File: rtl/sc_statemachine_pointtype_prescaler.sv
// Pacing up-counter: synchronous clear, enable, wraps to zero at TERMINAL.
// Exposes a registered terminal flag aligned with the count, plus the
// terminal flag of the upcoming count for consumers that register outputs.
module sc_pointtype_prescaler #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = 4'd9
) (
    input  logic SC_PRESCALER_CLOCK_50,
    input  logic SC_PRESCALER_RESET_InLow,
    input  logic SC_PRESCALER_clear_In,
    input  logic SC_PRESCALER_enable_In,
    output logic SC_PRESCALER_terminal_Out,
    output logic SC_PRESCALER_terminalNext_c
);

    logic [WIDTH-1:0] countReg;
    logic [WIDTH-1:0] countNext;
    logic             terminalReg;

    // Next count: clear wins over enable; wrap to zero after the terminal value.
    always_comb begin
        countNext = countReg;
        if (SC_PRESCALER_clear_In) begin
            countNext = '0;
        end else if (SC_PRESCALER_enable_In) begin
            countNext = (countReg == TERMINAL) ? '0 : countReg + WIDTH'(1);
        end
    end

    // Count and terminal flag registers.
    always_ff @(posedge SC_PRESCALER_CLOCK_50) begin
        if (!SC_PRESCALER_RESET_InLow) begin
            countReg    <= '0;
            terminalReg <= (TERMINAL == '0);
        end else begin
            countReg    <= countNext;
            terminalReg <= (countNext == TERMINAL);
        end
    end

    assign SC_PRESCALER_terminal_Out   = terminalReg;
    assign SC_PRESCALER_terminalNext_c = (countNext == TERMINAL);

endmodule

// File: rtl/sc_statemachine_pointtype.sv
// Sequencer for the point-type rotate register: clear, load, paced rotations
// in a latched direction, done pulse. All outputs are registered and equal the
// decode of the state/counters they are aligned with.
// Optional build macro POINTTYPE_BOUNCE_EN: after DONE the direction flips and
// the run restarts (ping-pong) until stop or reset; busy stays high in DONE.
module sc_statemachine_pointtype
    import sc_statemachine_pointtype_pkg::*;
#(
    parameter int unsigned                PRESCALER_WIDTH    = PRESCALER_WIDTH_DEF,
    parameter logic [PRESCALER_WIDTH-1:0] PRESCALER_TERMINAL = PRESCALER_TERMINAL_DEF,
    parameter int unsigned                STEP_WIDTH         = STEP_WIDTH_DEF,
    parameter logic [STEP_WIDTH-1:0]      STEP_COUNT         = STEP_COUNT_DEF
) (
    input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic       SC_STATEMACHINEPOINT_RESET_InLow,
    input  logic       SC_STATEMACHINEPOINT_start_InLow,
    input  logic       SC_STATEMACHINEPOINT_stop_InLow,
    input  logic       SC_STATEMACHINEPOINT_clear_InLow,
    input  logic       SC_STATEMACHINEPOINT_direction_In,
    output logic       SC_STATEMACHINEPOINT_clear_OutLow,
    output logic       SC_STATEMACHINEPOINT_load_OutLow,
    output logic [1:0] SC_STATEMACHINEPOINT_shiftselection_Out,
    output logic       SC_STATEMACHINEPOINT_T0_OutLow,
    output logic       SC_STATEMACHINEPOINT_upcount_out,
    output logic       SC_STATEMACHINEPOINT_busy_Out,
    output logic       SC_STATEMACHINEPOINT_done_Out
);

    stateT                 stateReg;
    stateT                 stateNext;
    logic [STEP_WIDTH-1:0] stepReg;
    logic [STEP_WIDTH-1:0] stepNext;
    logic [STEP_WIDTH-1:0] stepInc;
    logic                  dirReg;
    logic                  dirNext;
    logic                  busyNext;

    logic                  prescClear;
    logic                  prescEnable;
    logic                  prescTerminal;
    logic                  prescTerminalNext;

    logic                  clearLowReg;
    logic                  loadLowReg;
    logic [1:0]            shiftSelReg;
    logic                  t0LowReg;
    logic                  upcountReg;
    logic                  busyReg;
    logic                  doneReg;

    // Prescaler only counts in RUN and sits at zero everywhere else.
    assign prescEnable = (stateReg == ST_RUN);
    assign prescClear  = (stateReg != ST_RUN);

    sc_pointtype_prescaler #(
        .WIDTH    (PRESCALER_WIDTH),
        .TERMINAL (PRESCALER_TERMINAL)
    ) u_prescaler (
        .SC_PRESCALER_CLOCK_50       (SC_STATEMACHINEPOINT_CLOCK_50),
        .SC_PRESCALER_RESET_InLow    (SC_STATEMACHINEPOINT_RESET_InLow),
        .SC_PRESCALER_clear_In       (prescClear),
        .SC_PRESCALER_enable_In      (prescEnable),
        .SC_PRESCALER_terminal_Out   (prescTerminal),
        .SC_PRESCALER_terminalNext_c (prescTerminalNext)
    );

    assign stepInc = stepReg + STEP_WIDTH'(1);

    // Next-state, step and direction-latch logic.
    always_comb begin
        stateNext = stateReg;
        stepNext  = stepReg;
        dirNext   = dirReg;
        case (stateReg)
            ST_IDLE: begin
                if (!SC_STATEMACHINEPOINT_clear_InLow) begin
                    stateNext = ST_CLEAR;
                end else if (!SC_STATEMACHINEPOINT_start_InLow) begin
                    stateNext = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                stateNext = ST_IDLE;
            end
            ST_LOAD: begin
                dirNext   = SC_STATEMACHINEPOINT_direction_In;
                stepNext  = '0;
                stateNext = (STEP_COUNT == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!SC_STATEMACHINEPOINT_stop_InLow) begin
                    stateNext = ST_IDLE;
                end else if (prescTerminal) begin
                    stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                stepNext = stepInc;
                if (!SC_STATEMACHINEPOINT_stop_InLow) begin
                    stateNext = ST_IDLE;
                end else if (stepInc == STEP_COUNT) begin
                    stateNext = ST_DONE;
                end else begin
                    stateNext = ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef POINTTYPE_BOUNCE_EN
                dirNext   = ~dirReg;
                stepNext  = '0;
                stateNext = ST_RUN;
`else
                stateNext = ST_IDLE;
`endif
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Busy covers the active part of a run; in ping-pong mode DONE is part of it.
    always_comb begin
        busyNext = (stateNext == ST_LOAD) || (stateNext == ST_RUN) ||
                   (stateNext == ST_SHIFT);
`ifdef POINTTYPE_BOUNCE_EN
        if (stateNext == ST_DONE) begin
            busyNext = 1'b1;
        end
`endif
    end

    // State, counters and registered output decode of the upcoming state.
    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50) begin
        if (!SC_STATEMACHINEPOINT_RESET_InLow) begin
            stateReg    <= ST_IDLE;
            stepReg     <= '0;
            dirReg      <= 1'b0;
            clearLowReg <= 1'b1;
            loadLowReg  <= 1'b1;
            shiftSelReg <= SHIFT_HOLD;
            t0LowReg    <= 1'b1;
            upcountReg  <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            stepReg     <= stepNext;
            dirReg      <= dirNext;
            clearLowReg <= (stateNext != ST_CLEAR);
            loadLowReg  <= (stateNext != ST_LOAD);
            shiftSelReg <= (stateNext == ST_SHIFT) ? shiftCodeFor(dirNext) : SHIFT_HOLD;
            t0LowReg    <= !((stateNext == ST_RUN) && (stepNext == '0));
            upcountReg  <= (stateNext == ST_RUN) && prescTerminalNext;
            busyReg     <= busyNext;
            doneReg     <= (stateNext == ST_DONE);
        end
    end

    assign SC_STATEMACHINEPOINT_clear_OutLow       = clearLowReg;
    assign SC_STATEMACHINEPOINT_load_OutLow        = loadLowReg;
    assign SC_STATEMACHINEPOINT_shiftselection_Out = shiftSelReg;
    assign SC_STATEMACHINEPOINT_T0_OutLow          = t0LowReg;
    assign SC_STATEMACHINEPOINT_upcount_out        = upcountReg;
    assign SC_STATEMACHINEPOINT_busy_Out           = busyReg;
    assign SC_STATEMACHINEPOINT_done_Out           = doneReg;

endmodule

// File: tb/tb_sc_statemachine_pointtype.sv
// Scoreboard bench for the point-type sequencer (default build).
// Stimulus pushes timestamped expected output events; a negedge monitor pops
// and compares whenever the DUT presents an active output.
module tb_sc_statemachine_pointtype;

    localparam int TERM  = 9;
    localparam int NSTEP = 8;
    localparam int PER   = TERM + 2;
    localparam int NEVER = 32'h3fff_ffff;

    localparam int EV_CLR   = 0;
    localparam int EV_LOAD  = 1;
    localparam int EV_T0    = 2;
    localparam int EV_UPC   = 3;
    localparam int EV_SHIFT = 4;
    localparam int EV_DONE  = 5;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } evT;

    logic       clk = 1'b0;
    logic       rstLow = 1'b0;
    logic       startLow = 1'b1;
    logic       stopLow = 1'b1;
    logic       clearInLow = 1'b1;
    logic       dirIn = 1'b0;
    logic       clearOutLow;
    logic       loadOutLow;
    logic [1:0] shiftSel;
    logic       t0Low;
    logic       upcount;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int expResetAt = 3;
    int finalAt = -1;
    int bLo = 1;
    int bHi = 0;
    evT sb[$];

    sc_statemachine_pointtype dut (
        .SC_STATEMACHINEPOINT_CLOCK_50           (clk),
        .SC_STATEMACHINEPOINT_RESET_InLow        (rstLow),
        .SC_STATEMACHINEPOINT_start_InLow        (startLow),
        .SC_STATEMACHINEPOINT_stop_InLow         (stopLow),
        .SC_STATEMACHINEPOINT_clear_InLow        (clearInLow),
        .SC_STATEMACHINEPOINT_direction_In       (dirIn),
        .SC_STATEMACHINEPOINT_clear_OutLow       (clearOutLow),
        .SC_STATEMACHINEPOINT_load_OutLow        (loadOutLow),
        .SC_STATEMACHINEPOINT_shiftselection_Out (shiftSel),
        .SC_STATEMACHINEPOINT_T0_OutLow          (t0Low),
        .SC_STATEMACHINEPOINT_upcount_out        (upcount),
        .SC_STATEMACHINEPOINT_busy_Out           (busy),
        .SC_STATEMACHINEPOINT_done_Out           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            EV_CLR:   return "clear";
            EV_LOAD:  return "load";
            EV_T0:    return "T0";
            EV_UPC:   return "upcount";
            EV_SHIFT: return "shift";
            default:  return "done";
        endcase
    endfunction

    function automatic void push(input int kind, input int val, input int c, input int cut);
        evT e;
        if (c <= cut) begin
            e.kind = kind;
            e.val  = val;
            e.cyc  = c;
            sb.push_back(e);
        end
    endfunction

    // Expected events of one run whose load is visible in cycle c0, truncated at cut.
    function automatic void pushRun(input int c0, input int dir, input int cut);
        push(EV_LOAD, 0, c0, cut);
        for (int t = 1; t <= TERM + 1; t++) push(EV_T0, 0, c0 + t, cut);
        for (int k = 1; k <= NSTEP; k++) begin
            push(EV_UPC, 0, c0 + PER * k - 1, cut);
            push(EV_SHIFT, (dir != 0) ? 2 : 1, c0 + PER * k, cut);
        end
        push(EV_DONE, 0, c0 + PER * NSTEP + 1, cut);
    endfunction

    function automatic void chkBit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
        end
    endfunction

    function automatic void popChk(input int kind, input int val);
        evT e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s cycle %0d: got val %0d want no event", kindName(kind), cyc, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got %s val %0d cycle %0d want %s val %0d cycle %0d",
                         kindName(kind), val, cyc, kindName(e.kind), e.val, e.cyc);
            end
        end
    endfunction

    // Monitor: compares presented outputs with the scoreboard and level checks.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cyc == expResetAt) begin
                chkBit("rst_clear_OutLow", clearOutLow, 1'b1);
                chkBit("rst_load_OutLow", loadOutLow, 1'b1);
                chkBit("rst_shiftsel_hi", shiftSel[1], 1'b0);
                chkBit("rst_shiftsel_lo", shiftSel[0], 1'b0);
                chkBit("rst_T0_OutLow", t0Low, 1'b1);
                chkBit("rst_upcount", upcount, 1'b0);
                chkBit("rst_done", done, 1'b0);
            end
            if (clearOutLow === 1'b0) popChk(EV_CLR, 0);
            if (loadOutLow === 1'b0) popChk(EV_LOAD, 0);
            if (t0Low === 1'b0) popChk(EV_T0, 0);
            if (upcount === 1'b1) popChk(EV_UPC, 0);
            if (shiftSel !== 2'b00) popChk(EV_SHIFT, int'(shiftSel));
            if (done === 1'b1) popChk(EV_DONE, 0);
            chkBit("busy", busy, (cyc >= bLo && cyc <= bHi));
            if (cyc == finalAt) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL pending_events: got %0d outstanding want 0 (next %s at cycle %0d)",
                             sb.size(), kindName(sb[0].kind), sb[0].cyc);
                end
            end
        end
    end

    // One start request; optional stop (after stopM shifts, stopOff RUN cycles later)
    // or reset (rstAt cycles after load). Direction and start are jittered mid-run.
    task automatic runOne(input int dir, input int stopM, input int stopOff, input int rstAt);
        int c0, cut, endC, lastShift;
        @(negedge clk);
        startLow = 1'b0;
        dirIn = dir[0];
        c0 = cyc + 1;
        lastShift = c0 + PER * NSTEP;
        cut = NEVER;
        if (stopM > 0) cut = c0 + PER * stopM + stopOff;
        if (rstAt > 0) cut = c0 + rstAt;
        pushRun(c0, dir, cut);
        bLo = c0;
        bHi = (cut < lastShift) ? cut : lastShift;
        endC = (cut < lastShift + 1) ? cut + 1 : lastShift + 1;
        while (cyc < endC + 3) begin
            @(negedge clk);
            startLow = 1'b1;
            stopLow = 1'b1;
            rstLow = 1'b1;
            if (cyc == c0) stopLow = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            if (cyc > c0 && $urandom_range(0, 3) == 0) dirIn = ~dirIn;
            if (cyc >= c0 && cyc <= endC - 1 && $urandom_range(0, 3) == 0) startLow = 1'b0;
            if (stopM > 0 && cyc == cut) stopLow = 1'b0;
            if (rstAt > 0 && cyc == cut) begin
                rstLow = 1'b0;
                expResetAt = cut + 1;
            end
        end
        startLow = 1'b1;
        stopLow = 1'b1;
        rstLow = 1'b1;
    endtask

    // Clear request held for k cycles, optionally together with start.
    task automatic clearTest(input int k, input int withStart);
        int c;
        @(negedge clk);
        c = cyc;
        clearInLow = 1'b0;
        startLow = (withStart != 0) ? 1'b0 : 1'b1;
        for (int j = 0; 2 * j <= k - 1; j++) push(EV_CLR, 0, c + 1 + 2 * j, NEVER);
        repeat (k) @(negedge clk);
        clearInLow = 1'b1;
        startLow = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int d;
        repeat (3) @(negedge clk);
        rstLow = 1'b1;
        repeat (2) @(negedge clk);

        runOne(0, 0, 0, 0);
        runOne(1, 0, 0, 0);
        runOne(int'($urandom_range(0, 1)), 3, 2, 0);
        clearTest(1, 1);
        clearTest(4, 1);
        runOne(0, 0, 0, 0);
        runOne(1, 0, 0, PER * 2);
        runOne(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                runOne(d, int'($urandom_range(1, NSTEP - 1)), int'($urandom_range(1, TERM + 1)), 0);
            else
                runOne(d, 0, 0, 0);
        end

        @(negedge clk);
        finalAt = cyc + 1;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_statemachine_pointtype.md
Name: sc_statemachine_pointtype

Overview:
Sequencer for the point-type rotate register. It drives the register's active-low clear and load strobes, its 2-bit shift-selection code, and its T0/upcount status inputs. One start request produces one load of the pattern, then STEP_COUNT paced single-bit rotations in a latched direction, then a done pulse. It sits between the game top-level controls (start/stop/clear/direction) and the point-type register instance.

Parameters:
PRESCALER_WIDTH, 4, width of the pacing counter.
PRESCALER_TERMINAL, 4'd9, terminal value of the pacing counter; one shift every TERMINAL+2 cycles.
STEP_WIDTH, 4, width of the step counter.
STEP_COUNT, 4'd8, number of rotations per run.

Ports:
SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, all logic on its rising edge.
SC_STATEMACHINEPOINT_RESET_InLow  in  1  reset, synchronous, active-low.
SC_STATEMACHINEPOINT_start_InLow  in  1  start request, level-sampled in IDLE.
SC_STATEMACHINEPOINT_stop_InLow  in  1  abort request in RUN/SHIFT.
SC_STATEMACHINEPOINT_clear_InLow  in  1  clear request, sampled in IDLE.
SC_STATEMACHINEPOINT_direction_In  in  1  0 = rotate left (code 01), 1 = rotate right (code 10); latched in LOAD.
SC_STATEMACHINEPOINT_clear_OutLow  out  1  to register clear input.
SC_STATEMACHINEPOINT_load_OutLow  out  1  to register load input.
SC_STATEMACHINEPOINT_shiftselection_Out  out  2  to register shift-selection input.
SC_STATEMACHINEPOINT_T0_OutLow  out  1  low during the first pacing interval of a run.
SC_STATEMACHINEPOINT_upcount_out  out  1  high for the one cycle where the prescaler is at terminal.
SC_STATEMACHINEPOINT_busy_Out  out  1  high in LOAD, RUN and SHIFT.
SC_STATEMACHINEPOINT_done_Out  out  1  one-cycle pulse at run completion.

Behaviour:
- Moore FSM. States: IDLE, CLEAR, LOAD, RUN, SHIFT, DONE. All outputs decode from the registered state and counters.
- Reset: RESET_InLow = 0 at a clock edge forces the following, overriding any state, including mid-run:
  - state IDLE; prescaler 0; step 0; direction latch 0.
  - Outputs: clear_OutLow = 1, load_OutLow = 1, shiftselection = 00, T0_OutLow = 1, upcount_out = 0, busy = 0, done = 0.
- IDLE:
  - clear_InLow = 0 goes to CLEAR. Clear has priority over start.
  - Otherwise start_InLow = 0 goes to LOAD.
  - Otherwise stay in IDLE.
- CLEAR: clear_OutLow = 0 for exactly 1 cycle, then IDLE. A held clear request re-enters CLEAR every other cycle.
- LOAD:
  - load_OutLow = 0 for 1 cycle; direction_In is latched; step is cleared.
  - Next state is RUN with prescaler = 0, or DONE directly if STEP_COUNT = 0.
- RUN:
  - The prescaler increments each cycle.
  - At prescaler == TERMINAL: upcount_out = 1 and the next state is SHIFT. The prescaler wraps to 0.
  - T0_OutLow = 0 while step == 0.
- SHIFT:
  - shiftselection = 01 (latched direction 0) or 10 (latched direction 1) for exactly 1 cycle; step increments.
  - Next state is DONE if the new step == STEP_COUNT, else RUN.
  - shiftselection = 00 in every other state.
- Pacing: first rotation at edge LOAD+TERMINAL+3; subsequent rotations every TERMINAL+2 cycles.
- DONE: done = 1 for 1 cycle, then IDLE. start is not re-sampled until the machine is back in IDLE.
- Stop:
  - stop_InLow = 0 in RUN or SHIFT goes to IDLE next; no done pulse.
  - A rotation already presented in SHIFT still takes effect.
  - Stop is ignored in other states.
- Inputs that change mid-run (direction, start) are ignored.
- The step counter compares for equality only and never wraps past STEP_COUNT.

Optional Feature:
POINTTYPE_BOUNCE_EN.
- Defined: DONE pulses done for 1 cycle, then toggles the direction latch, clears step and returns to RUN (ping-pong) until stop or reset. busy stays high during DONE.
- Undefined: DONE goes to IDLE as above.

Decomposition:
- Shared package: state encoding constants; shift codes (HOLD = 00, LEFT = 01, RIGHT = 10); default prescaler and step values.
- One natural sub-module: sc_pointtype_prescaler, a parameterized up-counter with synchronous clear, enable and terminal flag.

Test Plan:
- Reset then idle: hold RESET_InLow = 0 for 3 cycles -> all outputs at reset values; busy = 0; shiftselection = 00.
- Left run with defaults: start = 0 for 1 cycle, direction = 0 -> load_OutLow low 1 cycle; then 8 pulses of shiftselection = 01, each 11 cycles apart; T0_OutLow low only before the first; done pulse 1 cycle after the 8th SHIFT.
- Right run with latched direction: direction = 1 at LOAD, toggled to 0 mid-run -> all 8 codes = 10.
- Stop during run: stop_InLow = 0 in RUN after the 3rd shift -> IDLE next cycle; exactly 3 shifts; no done.
- Clear priority: clear = 0 and start = 0 together in IDLE -> clear_OutLow low 1 cycle, no load; start alone afterwards -> LOAD.
- Reset mid-run and bounce: reset asserted in SHIFT -> IDLE, outputs at reset values next cycle. With POINTTYPE_BOUNCE_EN: 8 codes of 01, done pulse, 8 codes of 10, continuing until stop.
